// File: rtl/seq_det_pkg.sv
// Shared defaults and config helpers for the parametrised serial pattern detector.
// Pure declarations: no logic, no latency, no flow control.
package seq_det_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_CNT_W = 8;
  localparam logic [7:0] DEF_PATTERN = 8'b0001_0111;
  localparam int DEF_LEN = 5;

  // A programmed length is usable only if it selects at least one bit and fits the history.
  function automatic bit len_legal(input int len, input int w);
    return (len >= 1) && (len <= w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1.
// Latency: count updates on the edge that samples clr/inc; no backpressure (inc never stalls).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count_nxt = count + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime pattern/length/overlap and a saturating match counter.
// Latency: match pulses 1 clock after the completing bit; no backpressure, one qualified bit per clock.
module seq_detector_param #(
  parameter int              W           = seq_det_pkg::DEF_W,
  parameter int              CNT_W       = seq_det_pkg::DEF_CNT_W,
  parameter logic [W-1:0]    DEF_PATTERN = W'(seq_det_pkg::DEF_PATTERN),
  parameter int              DEF_LEN     = seq_det_pkg::DEF_LEN,
  parameter bit              DEF_OVERLAP = 1'b1,
  localparam int             LW          = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [W-1:0]     cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_overlap,
  output logic             cfg_err,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  import seq_det_pkg::*;

  logic [W-1:0]  hist;
  logic [W-1:0]  pat;
  logic [W-1:0]  mask;
  logic [W-1:0]  cand;
  logic [LW-1:0] fill;
  logic [LW-1:0] fill_nxt;
  logic [LW-1:0] len;
  logic          ovl;
  logic          cfg_ok;
  logic          cfg_bad;
  logic          accept;
  logic          fill_ok;
  logic          hit;

  always_comb begin
    mask = '0;
    for (int i = 0; i < W; i++) begin
      mask[i] = (LW'(i) < len);
    end
  end

  // A legal load wins over a coincident bit: that bit belongs to neither the old nor the new pattern.
  assign cfg_ok  = cfg_load && len_legal(int'(cfg_len), W);
  assign cfg_bad = cfg_load && !len_legal(int'(cfg_len), W);
  assign accept  = in_valid && !cfg_ok;
  assign cand    = {hist[W-2:0], in_bit};
  assign fill_ok = (({1'b0, fill} + (LW + 1)'(1)) >= {1'b0, len});
  assign hit     = accept && fill_ok && (((cand ^ pat) & mask) == '0);

  always_comb begin
    fill_nxt = fill;
    if (hit && !ovl) begin
      fill_nxt = '0;
    end else if (fill != LW'(W)) begin
      fill_nxt = fill + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat     <= DEF_PATTERN;
      len     <= LW'(DEF_LEN);
      ovl     <= DEF_OVERLAP;
      hist    <= '0;
      fill    <= '0;
      match   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      match   <= hit;
      cfg_err <= cfg_bad;
      if (cfg_ok) begin
        pat  <= cfg_pattern;
        len  <= cfg_len;
        ovl  <= cfg_overlap;
        hist <= '0;
        fill <= '0;
      end else if (accept) begin
        hist <= cand;
        fill <= fill_nxt;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (hit),
    .count(match_count)
  );

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector with a runtime-programmable pattern, pattern length and overlap mode, plus a saturating match counter. It is the general successor of the fixed-pattern lab FSM detectors. It sits between a serial bit source (switch/debounce or shift-out logic) and display or interrupt logic, and consumes one qualified bit per clock.

## Interface
- `W`: default 8. Maximum pattern length in bits, ≥2.
- `CNT_W`: default 8. Match counter width.
- `DEF_PATTERN`: default 8'b0001_0111. Pattern loaded at reset, right-aligned.
- `DEF_LEN`: default 5. Pattern length loaded at reset, 1..W.
- `DEF_OVERLAP`: default 1. Overlap mode loaded at reset.
- `LW` (derived, not overridable): $clog2(W+1).

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset (asserts on negedge, releases synchronously to `clk`).
- `cfg_load`  in  1  one-cycle strobe that loads `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern`  in  W  new pattern, right-aligned. `cfg_pattern[cfg_len-1]` is the first bit received.
- `cfg_len`  in  LW  new length, legal 1..W.
- `cfg_overlap`  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- `cfg_err`  out  1  registered pulse, one cycle, when `cfg_load` carries an illegal `cfg_len`.
- `in_valid`  in  1  `in_bit` is sampled this cycle.
- `in_bit`  in  1  serial data bit.
- `cnt_clr`  in  1  synchronous clear of `match_count`.
- `match`  out  1  registered one-cycle pulse per detected match.
- `match_count`  out  CNT_W  number of matches, saturates at all-ones.

## Operation
- Internal state:
  - history shift register `hist[W-1:0]`. On each accepted bit, `hist <= {hist[W-2:0], in_bit}`.
  - fill counter `fill` (0..W, saturating): the number of valid bits in history.
  - active configuration registers: `pat`, `len`, `ovl`.
- Match condition on an accepted bit: `{hist[len-2:0], in_bit} == pat[len-1:0]` and `fill + 1 >= len`. Only the low `len` bits are compared; upper bits are don't-care.
- On a match:
  - `match` is 1 for the next cycle.
  - `match_count` increments, unless it is already all-ones.
  - If `ovl = 0`, `fill` is set to 0; the shifted history is ignored because of the fill gate.
  - If `ovl = 1`, `fill` keeps counting.
- `cfg_load` with `cfg_len` in 1..W:
  - active config is replaced.
  - `hist` and `fill` are cleared.
  - `match_count` is unchanged.
  - A bit presented in the same cycle is discarded and cannot produce a match.
- `cfg_load` with `cfg_len` = 0 or > W:
  - config is not changed; history is kept.
  - `cfg_err` pulses.
  - A bit presented in the same cycle is processed normally.
- `cnt_clr` and a match in the same cycle: `match_count` becomes 1. `cnt_clr` alone: 0.
- `in_valid = 0`: no state change. The pattern spans only accepted bits, so gaps are transparent.
- `len = 1`: every accepted bit equal to `pat[0]` matches.

## Timing
- Reset values:
  - `match = 0`, `cfg_err = 0`, `match_count = 0`.
  - `hist = 0`, `fill = 0`.
  - `pat = DEF_PATTERN`, `len = DEF_LEN`, `ovl = DEF_OVERLAP`.
- Latency: the bit completing a pattern is sampled at edge N, and `match` is high during cycle N+1 (1 clock). The count updates on the same edge as `match`.
- Back-to-back matches in overlap mode produce consecutive high cycles of `match`, one per bit.
- Config loaded at edge N applies to the bit sampled at edge N+1.
- Reset asserted mid-pattern returns to reset values immediately. Partial history is lost and no match pulse is emitted.
- No combinational path from inputs to outputs.

## Structure
- Package `seq_det_pkg` holds:
  - default constants `DEF_W`, `DEF_CNT_W`, `DEF_PATTERN`, `DEF_LEN`.
  - function `len_legal(len, W)`.
- One sub-module: `sat_counter`, a parametrised saturating counter with `clr` and `inc` inputs. Clear-then-increment priority is implemented there.
- Top level contains the history, fill and config registers and the compare logic.

## Test plan
- **Reset defaults.** With the default pattern 10111, len 5, overlap on, feed 1,0,1,1,1. Expect `match` high in the cycle after the 5th bit, `match_count = 1`.
- **Overlap vs non-overlap.** Load pattern 101, len 3.
  - Overlap on, feed 1,0,1,0,1: 2 matches (after bits 3 and 5).
  - Reload with overlap off and feed the same stream: 1 match.
- **Gaps.** Pattern 10111 with `in_valid` low for 3 cycles between each bit: exactly 1 match.
- **Load collision.** `cfg_load` (pattern 11, len 2) in the same cycle as `in_valid = 1`, `in_bit = 1`, followed by a single 1. Expect no match; a further 1 gives a match.
- **Illegal config.** `cfg_load` with `cfg_len = 0`, then with `cfg_len = W+1`. Each gives a `cfg_err` pulse, the old pattern still detects, and the history is intact.
- **Counter edges.** With CNT_W = 2:
  - 5 matches leave `match_count` at 3 (saturated).
  - `cnt_clr` coincident with a match gives 1.
  - Asynchronous reset mid-pattern gives 0, and the partial pattern does not complete after release.
